// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: shared types and constants
// for the four-digit seven-segment scanner.
package seg_scan_pkg;

    typedef logic [1:0] digit_t;

    localparam logic [3:0] AN_OFF  = 4'b1111;
    localparam logic [6:0] SEG_OFF = 7'b1111111;

endpackage

// File: rtl/hex7seg_lut.sv
// hex7seg_lut: hex nibble to active-low
// gfedcba glyph, purely combinational.
module hex7seg_lut
    import seg_scan_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    // glyph table, segment a in bit 0
    always_comb begin
        seg = SEG_OFF;
        unique case (hex)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
        endcase
    end

endmodule

// File: rtl/seg_scan4.sv
// seg_scan4: multiplexed four-digit hex display
// with frame-synchronous capture and dead time.
module seg_scan4
    import seg_scan_pkg::*;
#(
    parameter int PRESCALE_BITS = 16,
    parameter int DEAD_CYCLES   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] val,
    input  logic [3:0]  dp,
    input  logic        blank,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dpo,
    output logic        frame
);

    localparam logic [PRESCALE_BITS-1:0] ONE  =
        PRESCALE_BITS'(1);
    localparam logic [PRESCALE_BITS-1:0] DEAD =
        PRESCALE_BITS'(DEAD_CYCLES);

    logic [PRESCALE_BITS-1:0] cnt;
    digit_t                   idx;
    logic [15:0]              sh_val;
    logic [3:0]               sh_dp;
    logic                     sh_blank;

    logic       tick;
    logic       last;
    logic [3:0] nib;
    logic [6:0] glyph;
    logic [3:0] lz;
    logic       hide;
    logic       dead;

    assign tick = en && (cnt == '1);
    assign last = (idx == 2'd3);
    assign nib  = sh_val[{idx, 2'b00} +: 4];
    assign dead = (cnt < DEAD);

    // lz[i]: digit i and every digit above it are zero
    always_comb begin
        lz    = 4'b0000;
        lz[3] = (sh_val[15:12] == 4'h0);
        lz[2] = lz[3] && (sh_val[11:8] == 4'h0);
        lz[1] = lz[2] && (sh_val[7:4] == 4'h0);
    end

    assign hide = sh_blank && lz[idx];

    hex7seg_lut u_lut (
        .hex (nib),
        .seg (glyph)
    );

    // prescaler, digit index and frame-start shadow capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            idx      <= '0;
            sh_val   <= '0;
            sh_dp    <= '0;
            sh_blank <= 1'b0;
        end else if (en) begin
            cnt <= cnt + ONE;
            if (tick) begin
                idx <= idx + 2'd1;
                if (last) begin
                    sh_val   <= val;
                    sh_dp    <= dp;
                    sh_blank <= blank;
                end
            end
        end
    end

    // registered drive; dead time gates only the anodes so
    // segments settle while every digit is dark
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an    <= AN_OFF;
            seg   <= SEG_OFF;
            dpo   <= 1'b1;
            frame <= 1'b0;
        end else if (!en) begin
            an    <= AN_OFF;
            seg   <= SEG_OFF;
            dpo   <= 1'b1;
            frame <= 1'b0;
        end else begin
            frame <= tick && last;
            if (hide) begin
                an  <= AN_OFF;
                seg <= SEG_OFF;
                dpo <= 1'b1;
            end else begin
                an  <= dead ? AN_OFF : ~(4'b0001 << idx);
                seg <= glyph;
                dpo <= ~sh_dp[idx];
            end
        end
    end

endmodule

// File: doc/seg_scan4.md
SEG_SCAN4 -- requirements
Module: seg_scan4

Interface
REQ-001 Parameter PRESCALE_BITS, default 16: width of the prescaler, giving 2^PRESCALE_BITS clock cycles per digit slot.
REQ-002 Parameter DEAD_CYCLES, default 2: all-anodes-off cycles at the start of each slot; SHALL be less than 2^PRESCALE_BITS.
REQ-003 CLK  in  1  single system clock; all state SHALL be on its rising edge.
REQ-004 RST  in  1  asynchronous, active-low reset.
REQ-005 EN  in  1  scan enable; low freezes the scan and blanks the display.
REQ-006 VAL  in  16  four hex digits; VAL[3:0] is digit 0 (rightmost).
REQ-007 DP  in  4  decimal point request per digit, active-high.
REQ-008 BLANK  in  1  leading-zero blanking enable.
REQ-009 AN  out  4  digit anodes, active-low; AN[i] drives digit i.
REQ-010 SEG  out  7  segments gfedcba, active-low; SEG[0]=a.
REQ-011 DPO  out  1  decimal point segment, active-low.
REQ-012 FRAME  out  1  one-cycle pulse marking the start of each scan frame.

Function
REQ-013 The prescaler SHALL count 0 to 2^PRESCALE_BITS-1 and wrap; a tick is the cycle where the count equals its maximum.
REQ-014 On each tick, the digit index SHALL advance 0->1->2->3->0.
REQ-015 On a tick where the index is 3, VAL, DP and BLANK SHALL be captured into shadow registers.
- Only shadow values drive the display, so no frame shows a torn value.
REQ-016 FRAME SHALL be high for exactly the one cycle after that capture tick.
REQ-017 Blanking: while the prescaler count is below DEAD_CYCLES, AN SHALL be 4'b1111.
REQ-018 Display: otherwise, AN SHALL drive low only the bit of the current index.
- SEG SHALL carry the active-low hex glyph of the indexed shadow nibble.
- DPO SHALL be the inverse of the indexed shadow DP bit.
REQ-019 Glyphs SHALL be exactly:
- 0=1000000, 1=1111001, 2=0100100, 3=0110000
- 4=0011001, 5=0010010, 6=0000010, 7=1111000
- 8=0000000, 9=0010000, A=0001000, b=0000011
- C=1000110, d=0100001, E=0000110, F=0001110
REQ-020 Leading-zero blanking: when shadow BLANK is 1, digit i>0 SHALL be blanked (AN stays high, SEG=1111111, DPO=1) if it and every higher digit are zero.
- Digit 0 SHALL never be blanked.
REQ-021 AN, SEG, DPO and FRAME SHALL be registered, lagging prescaler/index state by one cycle.
REQ-022 When EN=0: prescaler and index SHALL hold; no capture SHALL occur; from the next cycle AN=1111, SEG=1111111, DPO=1, FRAME=0.
REQ-023 When EN returns to 1, the scan SHALL resume from the held index and count.
REQ-024 EN=0 on a tick cycle SHALL suppress that tick (no advance, no capture).

Reset
REQ-025 RST=0 SHALL immediately, without a clock edge, set:
- prescaler=0, index=0, shadows=0
- AN=1111, SEG=1111111, DPO=1, FRAME=0
REQ-026 After release, the display SHALL show shadow value 0 until the first capture.
- The first capture occurs 4*2^PRESCALE_BITS cycles after release, with EN held high.

Structure
REQ-027 Package seg_scan_pkg SHALL hold the digit-index typedef (2 bits) and the constants AN_OFF=4'b1111 and SEG_OFF=7'b1111111.
REQ-028 The glyph table SHALL live in one combinational sub-module, hex7seg_lut (4-bit in, 7-bit active-low out).
REQ-029 Prescaler, index, shadow and output registers SHALL reside in seg_scan4.

Verification (PRESCALE_BITS=4, DEAD_CYCLES=2)
REQ-030 Reset: assert RST=0 between clock edges -> AN=1111, SEG=1111111, DPO=1, FRAME=0 at once, with no edge required.
REQ-031 Scan order: VAL=16'h1234, DP=4'b0001, BLANK=0, EN=1; in the second frame -> each slot is 16 cycles (2 off, then 14 on):
- AN=1110, SEG=0011001, DPO=0
- then AN=1101, SEG=0110000
- then AN=1011, SEG=0100100
- then AN=0111, SEG=1111001
- FRAME pulses every 64 cycles
REQ-032 Leading-zero blanking: VAL=16'h0005, BLANK=1 -> digit 3-1 slots keep AN=1111; digit 0 shows SEG=0010010.
- VAL=0, BLANK=1 -> digit 0 shows SEG=1000000.
REQ-033 No tearing: change VAL from 16'h1234 to 16'hABCD during the digit-1 slot -> digits 2 and 3 still show 2 and 1; the next frame shows D, C, b, A.
REQ-034 Enable: drop EN for 10 cycles mid-slot -> AN=1111 from the next cycle; on re-enable, the same digit resumes at the held count; frame period is extended by exactly 10 cycles.
